// File: rtl/elevator_pkg.sv
// elevator_pkg: shared defaults and scheduler state type for the elevator controller
package elevator_pkg;
  localparam int DEF_NUM_FLOORS = 8;
  localparam int DEF_FLOOR_W = 3;
  localparam int DEF_DWELL_CYCLES = 4;
  typedef enum logic [1:0] {IDLE, SERVE_UP, SERVE_DOWN, DWELL} sched_state_t;
endpackage

// File: rtl/floor_priority_pick.sv
// floor_priority_pick: nearest pending floor strictly above and strictly below the car
module floor_priority_pick #(
  parameter int NUM_FLOORS = elevator_pkg::DEF_NUM_FLOORS,
  parameter int FLOOR_W = elevator_pkg::DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  up_hit,
  output logic [FLOOR_W-1:0]    up_floor,
  output logic                  dn_hit,
  output logic [FLOOR_W-1:0]    dn_floor
);
  always_comb begin
    up_hit = 1'b0;
    up_floor = '0;
    dn_hit = 1'b0;
    dn_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pending[i] && i > int'(current_floor)) begin
        up_hit = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pending[i] && i < int'(current_floor)) begin
        dn_hit = 1'b1;
        dn_floor = FLOOR_W'(i);
      end
  end
endmodule

// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler: SCAN-ordered target selection over a pending-floor bitmap
module floor_request_scheduler import elevator_pkg::*; #(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W = DEF_FLOOR_W,
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] btn_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  arrived,
  output logic [FLOOR_W-1:0]    floor_request,
  output logic                  request_valid,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy
);
  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  sched_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_FLOORS-1:0] here, clr;
  logic [FLOOR_W-1:0] up_floor, dn_floor, fr_n;
  logic up_hit, dn_hit, here_pend, rv_n, dir_n;
  floor_priority_pick #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_pick (
    .pending(pending),
    .current_floor(current_floor),
    .up_hit(up_hit),
    .up_floor(up_floor),
    .dn_hit(dn_hit),
    .dn_floor(dn_floor)
  );
  assign here = int'(current_floor) < NUM_FLOORS ? NUM_FLOORS'(1) << current_floor : '0;
  assign here_pend = |(pending & here);
  assign clr = (arrived || state == DWELL || (state == IDLE && here_pend)) ? here : '0;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = here_pend ? DWELL : up_hit ? SERVE_UP : dn_hit ? SERVE_DOWN : IDLE;
      SERVE_UP:   state_n = arrived ? DWELL : up_hit ? SERVE_UP : IDLE;
      SERVE_DOWN: state_n = arrived ? DWELL : dn_hit ? SERVE_DOWN : IDLE;
      DWELL:      state_n = cnt != '0 ? DWELL : (dir_up && up_hit) ? SERVE_UP :
                            dn_hit ? SERVE_DOWN : up_hit ? SERVE_UP : IDLE;
      default:    state_n = IDLE;
    endcase
    // counter idles at its load value so every DWELL entry starts a full period
    cnt_n = (state == DWELL && cnt != '0) ? cnt - CW'(1) : DWELL_LOAD;
    dir_n = state_n == SERVE_UP ? 1'b1 : state_n == SERVE_DOWN ? 1'b0 : dir_up;
    rv_n = state_n == SERVE_UP || state_n == SERVE_DOWN;
    fr_n = state_n == SERVE_UP ? up_floor : state_n == SERVE_DOWN ? dn_floor :
           state_n == DWELL ? current_floor : floor_request;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= DWELL_LOAD;
      pending <= '0;
      floor_request <= '0;
      request_valid <= 1'b0;
      dir_up <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pending <= (pending | btn_req) & ~clr;
      floor_request <= fr_n;
      request_valid <= rv_n;
      dir_up <= dir_n;
    end
endmodule

// File: tb/tb_floor_request_scheduler.sv
// tb_floor_request_scheduler: directed and random stimulus against a behavioural SCAN model
module tb_floor_request_scheduler;
  localparam int NF = 8;
  localparam int DW = 4;
  localparam int M_IDLE = 0, M_UP = 1, M_DN = 2, M_DWELL = 3;
  logic clk, rst, arrived, request_valid, dir_up, busy;
  logic [NF-1:0] btn_req, pending;
  logic [2:0] current_floor, floor_request;
  int checks = 0, errors = 0;
  logic [NF-1:0] m_pend;
  int m_mode, m_left, m_fr;
  bit m_rv, m_dir;
  int car;
  int tq[$];
  floor_request_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(3), .DWELL_CYCLES(DW)) dut (
    .clk(clk),
    .rst(rst),
    .btn_req(btn_req),
    .current_floor(current_floor),
    .arrived(arrived),
    .floor_request(floor_request),
    .request_valid(request_valid),
    .pending(pending),
    .dir_up(dir_up),
    .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int find_up(input logic [NF-1:0] p, input int cf);
    for (int f = cf + 1; f < NF; f++) if (p[f]) return f;
    return -1;
  endfunction
  function automatic int find_dn(input logic [NF-1:0] p, input int cf);
    for (int f = cf - 1; f >= 0; f--) if (p[f]) return f;
    return -1;
  endfunction
  task automatic compare_all(input string pfx);
    chk({pfx, "_pending"}, int'(pending), int'(m_pend));
    chk({pfx, "_floor_request"}, int'(floor_request), m_fr);
    chk({pfx, "_request_valid"}, int'(request_valid), int'(m_rv));
    chk({pfx, "_dir_up"}, int'(dir_up), int'(m_dir));
    chk({pfx, "_busy"}, int'(busy), int'(m_mode != M_IDLE));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_pend = '0; m_mode = M_IDLE; m_left = 0; m_fr = 0; m_rv = 0; m_dir = 1;
    compare_all("rst");
    #1;
    rst = 1'b0;
  endtask
  task automatic step(input logic [NF-1:0] b, input logic [2:0] f, input logic a);
    int up, dn, nm, nl, nfr;
    bit here, clear, nrv, ndir;
    logic [NF-1:0] oh, np;
    btn_req = b; current_floor = f; arrived = a;
    up = find_up(m_pend, int'(f));
    dn = find_dn(m_pend, int'(f));
    oh = NF'(1) << f;
    here = (m_pend & oh) != '0;
    clear = a || m_mode == M_DWELL || (m_mode == M_IDLE && here);
    np = (m_pend | b) & ~(clear ? oh : '0);
    nm = m_mode; nl = m_left; ndir = m_dir;
    case (m_mode)
      M_IDLE: if (here) begin nm = M_DWELL; nl = DW; end
              else if (up >= 0) nm = M_UP;
              else if (dn >= 0) nm = M_DN;
      M_UP:   if (a) begin nm = M_DWELL; nl = DW; end else if (up < 0) nm = M_IDLE;
      M_DN:   if (a) begin nm = M_DWELL; nl = DW; end else if (dn < 0) nm = M_IDLE;
      default: if (m_left > 1) nl = m_left - 1;
               else if (m_dir && up >= 0) nm = M_UP;
               else if (dn >= 0) nm = M_DN;
               else if (up >= 0) nm = M_UP;
               else nm = M_IDLE;
    endcase
    nfr = m_fr; nrv = 0;
    if (nm == M_UP) begin nfr = up; nrv = 1; ndir = 1; end
    else if (nm == M_DN) begin nfr = dn; nrv = 1; ndir = 0; end
    else if (nm == M_DWELL) nfr = int'(f);
    @(posedge clk);
    #1;
    m_pend = np; m_mode = nm; m_left = nl; m_fr = nfr; m_rv = nrv; m_dir = ndir;
    compare_all("step");
    btn_req = '0; arrived = 1'b0;
  endtask
  task automatic run_car(input int n);
    for (int i = 0; i < n; i++) begin
      bit prv, a;
      prv = request_valid;
      a = request_valid && car == int'(floor_request);
      step('0, 3'(car), a);
      if (request_valid && !prv) tq.push_back(int'(floor_request));
      if (request_valid && car != int'(floor_request)) car += int'(floor_request) > car ? 1 : -1;
    end
  endtask
  initial begin
    rst = 1'b1; btn_req = '0; current_floor = '0; arrived = 1'b0;
    #6;
    do_reset();
    // basic up from floor 1 to floor 5
    step('0, 3'd1, 0);
    step(8'h20, 3'd1, 0);
    chk("basic_pending", int'(pending), 'h20);
    step('0, 3'd1, 0);
    chk("basic_target", int'(floor_request), 5);
    chk("basic_valid", int'(request_valid), 1);
    chk("basic_dir", int'(dir_up), 1);
    for (int f = 2; f <= 4; f++) step('0, 3'(f), 0);
    step('0, 3'd5, 1);
    chk("basic_arr_pending", int'(pending), 0);
    chk("basic_arr_valid", int'(request_valid), 0);
    for (int i = 0; i < DW; i++) step('0, 3'd5, 0);
    chk("basic_idle", int'(busy), 0);
    // async reset in the middle of SERVE_UP
    step(8'h90, 3'd0, 0);
    step('0, 3'd0, 0);
    chk("pre_rst_pending", int'(pending), 'h90);
    chk("pre_rst_busy", int'(busy), 1);
    do_reset();
    // SCAN ordering from floor 3 going up
    car = 3;
    step('0, 3'd3, 0);
    tq.delete();
    step(8'h52, 3'd3, 0);
    run_car(60);
    chk("scan_count", tq.size(), 3);
    if (tq.size() == 3) begin
      chk("scan_t0", tq[0], 4);
      chk("scan_t1", tq[1], 6);
      chk("scan_t2", tq[2], 1);
    end
    chk("scan_dir", int'(dir_up), 0);
    // retarget to a closer floor
    car = 2;
    step('0, 3'd2, 0);
    step(8'h80, 3'd2, 0);
    step('0, 3'd2, 0);
    chk("retgt_first", int'(floor_request), 7);
    step(8'h10, 3'd2, 0);
    step('0, 3'd2, 0);
    chk("retgt_new", int'(floor_request), 4);
    chk("retgt_keep7", int'(pending[7]), 1);
    run_car(40);
    chk("retgt_drained", int'(pending), 0);
    // clear wins over press at the arrival floor
    step(8'h10, 3'd7, 0);
    step('0, 3'd7, 0);
    step('0, 3'd6, 0);
    step('0, 3'd5, 0);
    step(8'h10, 3'd4, 1);
    chk("simul_arr", int'(pending[4]), 0);
    step(8'h10, 3'd4, 0);
    chk("simul_dwell", int'(pending[4]), 0);
    for (int i = 0; i < DW; i++) step('0, 3'd4, 0);
    // press at own floor while idle
    step('0, 3'd2, 0);
    step(8'h04, 3'd2, 0);
    step('0, 3'd2, 0);
    chk("own_busy", int'(busy), 1);
    chk("own_valid", int'(request_valid), 0);
    chk("own_pending", int'(pending), 0);
    for (int i = 0; i < DW; i++) step('0, 3'd2, 0);
    chk("own_idle", int'(busy), 0);
    // random traffic with a car that follows the target
    car = 2;
    for (int i = 0; i < 1500; i++) begin
      logic [NF-1:0] b;
      bit a;
      b = $urandom_range(0, 5) == 0 ? NF'(1) << $urandom_range(0, NF - 1) : '0;
      if ($urandom_range(0, 40) == 0) b = NF'($urandom);
      a = (request_valid && car == int'(floor_request)) || $urandom_range(0, 31) == 0;
      if (i == 700) do_reset();
      step(b, 3'(car), a);
      if (request_valid && car != int'(floor_request) && $urandom_range(0, 1) == 1)
        car += int'(floor_request) > car ? 1 : -1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
